// File: rtl/ipm2l_mc_fifo_pkg.sv
// Shared sizing helpers and flag reset values for the multi-channel FIFO.
package ipm2l_mc_fifo_pkg;

    localparam logic FLAG_RST_FULL         = 1'b0;
    localparam logic FLAG_RST_EMPTY        = 1'b1;
    localparam logic FLAG_RST_ALMOST_FULL  = 1'b0;
    localparam logic FLAG_RST_ALMOST_EMPTY = 1'b1;

    function automatic int calc_chw(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    function automatic int calc_lw(input int depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/ipm2l_mc_fifo_chan_ctrl.sv
// Per-channel pointer, level and flag bookkeeping for the multi-channel FIFO.
// Sticky overflow/underflow flags exist only with IPM2L_MC_FIFO_ERR_FLAG_EN defined.
module ipm2l_mc_fifo_chan_ctrl
    import ipm2l_mc_fifo_pkg::*;
#(
    parameter int C_DEPTH_WIDTH      = 6,
    parameter int C_ALMOST_FULL_NUM  = 60,
    parameter int C_ALMOST_EMPTY_NUM = 4
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_wr_req,
    input  logic                                 i_rd_req,
    input  logic                                 i_flush,
    output logic                                 o_wr_acc,
    output logic                                 o_rd_acc,
    output logic [C_DEPTH_WIDTH-1:0]             o_wr_ptr,
    output logic [C_DEPTH_WIDTH-1:0]             o_rd_ptr,
    output logic [calc_lw(C_DEPTH_WIDTH)-1:0]    o_level,
    output logic                                 o_full,
    output logic                                 o_empty,
    output logic                                 o_almost_full,
    output logic                                 o_almost_empty
`ifdef IPM2L_MC_FIFO_ERR_FLAG_EN
    ,
    output logic                                 o_overflow,
    output logic                                 o_underflow
`endif
);

    localparam int LW = calc_lw(C_DEPTH_WIDTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(2 ** C_DEPTH_WIDTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(C_ALMOST_FULL_NUM);
    localparam logic [LW-1:0] LVL_AE   = LW'(C_ALMOST_EMPTY_NUM);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [C_DEPTH_WIDTH-1:0] PTR_ONE = C_DEPTH_WIDTH'(1);

    logic [C_DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [C_DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]            r_level;
    logic                     r_full;
    logic                     r_empty;
    logic                     r_almost_full;
    logic                     r_almost_empty;
    logic [LW-1:0]            w_level_nxt;

    // Registered flags gate acceptance, so an empty channel never forwards a same-cycle write.
    assign o_wr_acc = i_wr_req && !r_full  && !i_flush;
    assign o_rd_acc = i_rd_req && !r_empty && !i_flush;

    always_comb begin
        w_level_nxt = r_level;
        case ({o_wr_acc, o_rd_acc})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= FLAG_RST_FULL;
            r_empty        <= FLAG_RST_EMPTY;
            r_almost_full  <= FLAG_RST_ALMOST_FULL;
            r_almost_empty <= FLAG_RST_ALMOST_EMPTY;
        end else begin
            if (o_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (o_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level        <= w_level_nxt;
            r_full         <= (w_level_nxt == LVL_FULL);
            r_empty        <= (w_level_nxt == '0);
            r_almost_full  <= (w_level_nxt >= LVL_AF);
            r_almost_empty <= (w_level_nxt <= LVL_AE);
        end
    end

`ifdef IPM2L_MC_FIFO_ERR_FLAG_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_req && r_full)  r_overflow  <= 1'b1;
            if (i_rd_req && r_empty) r_underflow <= 1'b1;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`else
    // Rejected requests leave no trace when error flags are not built.
`endif

    assign o_wr_ptr       = r_wr_ptr;
    assign o_rd_ptr       = r_rd_ptr;
    assign o_level        = r_level;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;

endmodule

// File: rtl/ipm2l_mc_fifo.sv
// Multi-channel FIFO: one shared storage array split into fixed per-channel regions.
// Define IPM2L_MC_FIFO_ERR_FLAG_EN to add the sticky overflow/underflow ports.
module ipm2l_mc_fifo
    import ipm2l_mc_fifo_pkg::*;
#(
    parameter int C_CH_NUM           = 4,
    parameter int C_DATA_WIDTH       = 32,
    parameter int C_DEPTH_WIDTH      = 6,
    parameter int C_ALMOST_FULL_NUM  = 60,
    parameter int C_ALMOST_EMPTY_NUM = 4
)(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [calc_chw(C_CH_NUM)-1:0]                 wr_ch,
    input  logic                                          wr_en,
    input  logic [C_DATA_WIDTH-1:0]                       wr_data,
    input  logic [calc_chw(C_CH_NUM)-1:0]                 rd_ch,
    input  logic                                          rd_en,
    output logic [C_DATA_WIDTH-1:0]                       rd_data,
    output logic                                          rd_valid,
    input  logic [C_CH_NUM-1:0]                           ch_flush,
    output logic [C_CH_NUM-1:0]                           full,
    output logic [C_CH_NUM-1:0]                           empty,
    output logic [C_CH_NUM-1:0]                           almost_full,
    output logic [C_CH_NUM-1:0]                           almost_empty,
    output logic [C_CH_NUM*calc_lw(C_DEPTH_WIDTH)-1:0]    water_level
`ifdef IPM2L_MC_FIFO_ERR_FLAG_EN
    ,
    output logic [C_CH_NUM-1:0]                           overflow,
    output logic [C_CH_NUM-1:0]                           underflow
`endif
);

    localparam int CHW   = calc_chw(C_CH_NUM);
    localparam int LW    = calc_lw(C_DEPTH_WIDTH);
    localparam int DEPTH = 2 ** C_DEPTH_WIDTH;
    localparam int AW    = CHW + C_DEPTH_WIDTH;

    logic [C_DATA_WIDTH-1:0]  r_mem [C_CH_NUM*DEPTH];
    logic [C_DATA_WIDTH-1:0]  r_rd_data;
    logic                     r_rd_valid;
    logic [C_CH_NUM-1:0]      w_wr_acc;
    logic [C_CH_NUM-1:0]      w_rd_acc;
    logic [C_DEPTH_WIDTH-1:0] w_wr_ptr [C_CH_NUM];
    logic [C_DEPTH_WIDTH-1:0] w_rd_ptr [C_CH_NUM];
    logic [AW-1:0]            w_wr_addr;
    logic [AW-1:0]            w_rd_addr;

    for (genvar n = 0; n < C_CH_NUM; n++) begin : g_chan
        ipm2l_mc_fifo_chan_ctrl #(
            .C_DEPTH_WIDTH      (C_DEPTH_WIDTH),
            .C_ALMOST_FULL_NUM  (C_ALMOST_FULL_NUM),
            .C_ALMOST_EMPTY_NUM (C_ALMOST_EMPTY_NUM)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .i_wr_req       (wr_en && (wr_ch == CHW'(n))),
            .i_rd_req       (rd_en && (rd_ch == CHW'(n))),
            .i_flush        (ch_flush[n]),
            .o_wr_acc       (w_wr_acc[n]),
            .o_rd_acc       (w_rd_acc[n]),
            .o_wr_ptr       (w_wr_ptr[n]),
            .o_rd_ptr       (w_rd_ptr[n]),
            .o_level        (water_level[n*LW +: LW]),
            .o_full         (full[n]),
            .o_empty        (empty[n]),
            .o_almost_full  (almost_full[n]),
`ifdef IPM2L_MC_FIFO_ERR_FLAG_EN
            .o_overflow     (overflow[n]),
            .o_underflow    (underflow[n]),
`endif
            .o_almost_empty (almost_empty[n])
        );
    end

    // At most one channel accepts each direction, so OR-ing the selected addresses is safe.
    always_comb begin
        w_wr_addr = '0;
        w_rd_addr = '0;
        for (int n = 0; n < C_CH_NUM; n++) begin
            if (w_wr_acc[n]) w_wr_addr = {CHW'(n), w_wr_ptr[n]};
            if (w_rd_acc[n]) w_rd_addr = {CHW'(n), w_rd_ptr[n]};
        end
    end

    always_ff @(posedge clk) begin
        if (|w_wr_acc) r_mem[w_wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= |w_rd_acc;
            if (|w_rd_acc) r_rd_data <= r_mem[w_rd_addr];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule
